mem_add_xfer_ctrl: RTL and testbench
====================================

// Module: mem_add_xfer_ctrl
// PURPOSE
//  Sequences the memory-to-memory add transfer: for each of LEN words, reads operand A from
//  mem1 and operand B from mem2, holds them on DOut1/DOut2 for the 8-bit add datapath, then
//  writes ADDOut to mem3. Sits between the host start/done handshake and the three
//  synchronous memories. The adder stays external and combinational.
// PARAMETERS
//  DW  8  data width of memory words, operands and sum
//  AW  4  address width of all three memories and of the len counter
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   begin transfer; sampled only in IDLE
//  abort       in   1   cancel transfer; sampled in every non-IDLE state
//  src1_addr   in   AW  mem1 base address, captured on accepted start
//  src2_addr   in   AW  mem2 base address, captured on accepted start
//  dst_addr    in   AW  mem3 base address, captured on accepted start
//  len         in   AW  word count, captured on accepted start; 0 is legal
//  busy        out  1   high from the cycle after an accepted start until the return to IDLE
//  done        out  1   one-cycle pulse when all words are written
//  mem1_re     out  1   mem1 read enable
//  mem1_addr   out  AW  mem1 read address
//  mem1_rdata  in   DW  mem1 data, valid 1 cycle after mem1_re
//  mem2_re     out  1   mem2 read enable
//  mem2_addr   out  AW  mem2 read address
//  mem2_rdata  in   DW  mem2 data, valid 1 cycle after mem2_re
//  DOut1       out  DW  registered operand A to the adder
//  DOut2       out  DW  registered operand B to the adder
//  ADDOut      in   DW  adder sum (combinational from DOut2, DOut1)
//  mem3_we     out  1   mem3 write enable
//  mem3_addr   out  AW  mem3 write address
//  mem3_wdata  out  DW  mem3 write data (= ADDOut)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, all re/we = 0; all addrs, DOut1, DOut2, idx = 0.
//  - FSM states: IDLE, RD, LAT, ADD, WR, DONE. Outputs are Moore-decoded from registered state.
//  - IDLE: start=1 -> capture the bases and len, idx=0. If len=0 go to DONE, else go to RD.
//  - RD: mem1_re=mem2_re=1; mem1_addr=src1+idx, mem2_addr=src2+idx. Next state LAT.
//  - LAT: latch mem1_rdata->DOut1 and mem2_rdata->DOut2 at the end of the cycle. Next state ADD.
//  - ADD: operands stable so the adder settles. Next state WR.
//  - WR: mem3_we=1; mem3_addr=dst+idx; mem3_wdata=ADDOut. If idx==len-1 go to DONE,
//    else idx++ and go to RD.
//  - DONE: done=1 for exactly one cycle. Next state IDLE. busy=1 in DONE.
//  - Timing: 4 cycles per word. Total start-to-done = 4*len+1 cycles (len=0: 1 cycle).
//  - Address arithmetic is modulo 2^AW: base+idx wraps past 2^AW-1 to 0. Sum truncates to DW.
//  - start while busy is ignored; captured bases/len are unaffected.
//  - abort: next state is IDLE, no done pulse. An abort sampled in WR still completes that
//    cycle's write. start and abort together in IDLE: start wins, because abort is ignored in IDLE.
//  - rst_n low mid-transfer: immediate return to reset values; no partial write after deassert.
//  - Memory inputs are sampled only in LAT; read data is ignored in all other states.
// CONFIGURATION
//  MEM_ADD_OVF_CNT_EN defined:
//   - adds output ovf_cnt [AW:0].
//   - ovf_cnt is cleared on an accepted start.
//   - in WR, ovf_cnt increments when ADDOut < DOut1 (unsigned carry-out).
//   - ovf_cnt holds its value after done and after abort. Its reset value is 0.
//  MEM_ADD_OVF_CNT_EN undefined: no ovf_cnt port and no overflow logic; all other behaviour identical.
// TESTING
//  1 len=4, mem1={7,3,9,10}, mem2={7,1,10,10}, all bases 0 -> mem3={14,4,19,20}; done at cycle 17.
//  2 len=0, start -> done pulses 1 cycle later; no re/we ever asserted; busy high 1 cycle.
//  3 src1=14, src2=15, dst=15, len=3 -> addresses wrap: mem1 14,15,0; mem2 15,0,1; mem3 15,0,1.
//  4 len=4, abort in 2nd word's ADD -> exactly 1 write (word 0); IDLE next cycle; done never high.
//  5 start pulsed again mid-transfer and rst_n low during WR -> 2nd start ignored; after reset
//    all outputs are 0 and mem3_we stays 0.
//  6 MEM_ADD_OVF_CNT_EN: mem1={200,100}, mem2={100,100}, len=2 -> mem3={44,200}, ovf_cnt=1.

Source files
------------

// File: rtl/mem_add_xfer_ctrl.sv
// Memory-to-memory add sequencer: reads mem1/mem2, presents operands to an external adder, writes mem3.
// Optional overflow counter output (ovf_cnt) is enabled with `define MEM_ADD_OVF_CNT_EN.
module mem_add_xfer_ctrl #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] src1_addr,
   input  logic [AW-1:0] src2_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic          mem1_re,
   output logic [AW-1:0] mem1_addr,
   input  logic [DW-1:0] mem1_rdata,
   output logic          mem2_re,
   output logic [AW-1:0] mem2_addr,
   input  logic [DW-1:0] mem2_rdata,
   output logic [DW-1:0] DOut1,
   output logic [DW-1:0] DOut2,
   input  logic [DW-1:0] ADDOut,
   output logic          mem3_we,
   output logic [AW-1:0] mem3_addr,
   output logic [DW-1:0] mem3_wdata
`ifdef MEM_ADD_OVF_CNT_EN
   ,
   output logic [AW:0]   ovf_cnt
`endif
);

   typedef enum logic [2:0] {IDLE, RD, LAT, ADD, WR, DONE} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] src1_q, src1_d, src2_q, src2_d, dst_q, dst_d, len_q, len_d;
   logic [DW-1:0] dout1_q, dout1_d, dout2_q, dout2_d;
   logic          busy_q, busy_d, done_q, done_d;
   logic          rd_en_q, rd_en_d, we_q, we_d;
   logic [AW-1:0] mem1_addr_q, mem1_addr_d, mem2_addr_q, mem2_addr_d;
   logic [AW-1:0] mem3_addr_q, mem3_addr_d;
`ifdef MEM_ADD_OVF_CNT_EN
   logic [AW:0]   ovf_q, ovf_d;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      src1_d  = src1_q;
      src2_d  = src2_q;
      dst_d   = dst_q;
      len_d   = len_q;
      dout1_d = dout1_q;
      dout2_d = dout2_q;
`ifdef MEM_ADD_OVF_CNT_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               src1_d  = src1_addr;
               src2_d  = src2_addr;
               dst_d   = dst_addr;
               len_d   = len;
               idx_d   = '0;
`ifdef MEM_ADD_OVF_CNT_EN
               ovf_d   = '0;
`endif
               state_d = (len == '0) ? DONE : RD;
            end
         end
         RD:  state_d = LAT;
         LAT: begin
            dout1_d = mem1_rdata;
            dout2_d = mem2_rdata;
            state_d = ADD;
         end
         ADD: state_d = WR;
         WR: begin
`ifdef MEM_ADD_OVF_CNT_EN
            if (ADDOut < dout1_q) ovf_d = ovf_q + 1'b1;
`endif
            if (idx_q == (len_q - AW'(1))) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + AW'(1);
               state_d = RD;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Abort overrides every non-idle transition; the WR strobe already registered still lands.
      if (state_q != IDLE && abort) state_d = IDLE;
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_comb begin
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
      rd_en_d     = (state_d == RD);
      we_d        = (state_d == WR);
      mem1_addr_d = rd_en_d ? (src1_d + idx_d) : '0;
      mem2_addr_d = rd_en_d ? (src2_d + idx_d) : '0;
      mem3_addr_d = we_d ? (dst_d + idx_d) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         src1_q      <= '0;
         src2_q      <= '0;
         dst_q       <= '0;
         len_q       <= '0;
         dout1_q     <= '0;
         dout2_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         we_q        <= 1'b0;
         mem1_addr_q <= '0;
         mem2_addr_q <= '0;
         mem3_addr_q <= '0;
`ifdef MEM_ADD_OVF_CNT_EN
         ovf_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         src1_q      <= src1_d;
         src2_q      <= src2_d;
         dst_q       <= dst_d;
         len_q       <= len_d;
         dout1_q     <= dout1_d;
         dout2_q     <= dout2_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_en_q     <= rd_en_d;
         we_q        <= we_d;
         mem1_addr_q <= mem1_addr_d;
         mem2_addr_q <= mem2_addr_d;
         mem3_addr_q <= mem3_addr_d;
`ifdef MEM_ADD_OVF_CNT_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign mem1_re    = rd_en_q;
   assign mem2_re    = rd_en_q;
   assign mem1_addr  = mem1_addr_q;
   assign mem2_addr  = mem2_addr_q;
   assign DOut1      = dout1_q;
   assign DOut2      = dout2_q;
   assign mem3_we    = we_q;
   assign mem3_addr  = mem3_addr_q;
   assign mem3_wdata = we_q ? ADDOut : '0;
`ifdef MEM_ADD_OVF_CNT_EN
   assign ovf_cnt    = ovf_q;
`endif

endmodule

// File: tb/tb_mem_add_xfer_ctrl.sv
// Bench for mem_add_xfer_ctrl: memory models, external adder, transfer-level reference model.
module tb_mem_add_xfer_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] src1_addr = '0, src2_addr = '0, dst_addr = '0, len = '0;
   logic          busy, done, mem1_re, mem2_re, mem3_we;
   logic [AW-1:0] mem1_addr, mem2_addr, mem3_addr;
   logic [DW-1:0] mem1_rdata = '0, mem2_rdata = '0;
   logic [DW-1:0] DOut1, DOut2, ADDOut, mem3_wdata;
`ifdef MEM_ADD_OVF_CNT_EN
   logic [AW:0]   ovf_cnt;
`endif

   always #5 clk = ~clk;

   mem_add_xfer_ctrl #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .src1_addr(src1_addr), .src2_addr(src2_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done),
      .mem1_re(mem1_re), .mem1_addr(mem1_addr), .mem1_rdata(mem1_rdata),
      .mem2_re(mem2_re), .mem2_addr(mem2_addr), .mem2_rdata(mem2_rdata),
      .DOut1(DOut1), .DOut2(DOut2), .ADDOut(ADDOut),
      .mem3_we(mem3_we), .mem3_addr(mem3_addr), .mem3_wdata(mem3_wdata)
`ifdef MEM_ADD_OVF_CNT_EN
      , .ovf_cnt(ovf_cnt)
`endif
   );

   assign ADDOut = DOut1 + DOut2;

   logic [DW-1:0] m1 [DEPTH];
   logic [DW-1:0] m2 [DEPTH];
   logic [DW-1:0] m3 [DEPTH];

   // Synchronous memories; garbage on cycles without a read enable.
   always @(posedge clk) begin
      mem1_rdata <= mem1_re ? m1[mem1_addr] : DW'($urandom);
      mem2_rdata <= mem2_re ? m2[mem2_addr] : DW'($urandom);
      if (mem3_we) m3[mem3_addr] <= mem3_wdata;
   end

   logic [AW+DW-1:0] wr_q [$];
   logic [AW-1:0]    rd1_q [$];
   logic [AW-1:0]    rd2_q [$];
   int busy_cnt = 0;
   int done_cnt = 0;

   always @(negedge clk) begin
      if (mem3_we) wr_q.push_back({mem3_addr, mem3_wdata});
      if (mem1_re) rd1_q.push_back(mem1_addr);
      if (mem2_re) rd2_q.push_back(mem2_addr);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {busy, done, mem1_re, mem2_re, mem3_we, mem1_addr, mem2_addr, mem3_addr,
              DOut1, DOut2, mem3_wdata};
   endfunction

   function automatic logic [AW-1:0] wrap(input logic [AW-1:0] base, input int i);
      return AW'((int'(base) + i) % DEPTH);
   endfunction

   task automatic fill_mem();
      for (int i = 0; i < DEPTH; i++) begin
         m1[i] = DW'($urandom);
         m2[i] = DW'($urandom);
      end
   endtask

   // One transfer: ab = cycle (counted from the accepted start) in which abort is raised, 0 = none.
   task automatic xfer(input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [AW-1:0] d,
                       input logic [AW-1:0] l, input int ab, input bit mid);
      logic [AW+DW-1:0] exp_q [$];
      int b_w, b_r1, b_r2, b_b, b_d, done_at, nw, nr, exp_ovf, sum;
      @(posedge clk); #1;
      src1_addr = s1; src2_addr = s2; dst_addr = d; len = l;
      start = 1'b1;
      abort = 1'(($urandom_range(0, 1)));
      b_w = wr_q.size(); b_r1 = rd1_q.size(); b_r2 = rd2_q.size();
      b_b = busy_cnt; b_d = done_cnt;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      done_at = 0;
      for (int c = 1; c <= 80; c++) begin
         if (mid && c == 2) begin
            start = 1'b1;
            src1_addr = AW'($urandom); src2_addr = AW'($urandom);
            dst_addr = AW'($urandom); len = AW'($urandom);
         end
         if (c == 3) start = 1'b0;
         if (c == ab) abort = 1'b1;
         @(negedge clk);
         if (done && done_at == 0) done_at = c;
         @(posedge clk); #1;
         abort = 1'b0;
         if (done_at != 0 || (ab != 0 && c == ab)) break;
      end

      nw = (ab == 0) ? int'(l) : ((ab / 4 < int'(l)) ? ab / 4 : int'(l));
      nr = (ab == 0) ? int'(l) : (((ab + 3) / 4 < int'(l)) ? (ab + 3) / 4 : int'(l));
      exp_ovf = 0;
      for (int i = 0; i < nw; i++) begin
         sum = int'(m1[wrap(s1, i)]) + int'(m2[wrap(s2, i)]);
         if (sum > 255) exp_ovf++;
         exp_q.push_back({wrap(d, i), DW'(sum % 256)});
      end

      check("done_cycle", 64'(done_at), (ab == 0) ? 64'(4 * int'(l) + 1) : 64'(0));
      check("done_pulses", 64'(done_cnt - b_d), (ab == 0) ? 64'(1) : 64'(0));
      check("busy_cycles", 64'(busy_cnt - b_b), (ab == 0) ? 64'(4 * int'(l) + 1) : 64'(ab));
      check("wr_count", 64'(wr_q.size() - b_w), 64'(nw));
      for (int i = 0; i < nw && b_w + i < wr_q.size(); i++)
         check("wr_addr_data", 64'(wr_q[b_w + i]), 64'(exp_q[i]));
      check("rd1_count", 64'(rd1_q.size() - b_r1), 64'(nr));
      check("rd2_count", 64'(rd2_q.size() - b_r2), 64'(nr));
      for (int i = 0; i < nr && b_r1 + i < rd1_q.size() && b_r2 + i < rd2_q.size(); i++) begin
         check("rd1_addr", 64'(rd1_q[b_r1 + i]), 64'(wrap(s1, i)));
         check("rd2_addr", 64'(rd2_q[b_r2 + i]), 64'(wrap(s2, i)));
      end
      @(negedge clk);
      check("idle_after", {62'd0, busy, done}, 64'd0);
`ifdef MEM_ADD_OVF_CNT_EN
      check("ovf_cnt", 64'(ovf_cnt), 64'(exp_ovf));
`endif
   endtask

   int b_w, b_b, ab;
   logic [AW-1:0] rl;

   initial begin
      fill_mem();
      repeat (2) @(negedge clk);
      check("reset_outs", outs(), 64'd0);
`ifdef MEM_ADD_OVF_CNT_EN
      check("reset_ovf", 64'(ovf_cnt), 64'd0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Basic four-word add from base 0.
      m1[0] = 8'd7; m1[1] = 8'd3; m1[2] = 8'd9;  m1[3] = 8'd10;
      m2[0] = 8'd7; m2[1] = 8'd1; m2[2] = 8'd10; m2[3] = 8'd10;
      xfer(4'd0, 4'd0, 4'd0, 4'd4, 0, 1'b0);
      check("m3_0", 64'(m3[0]), 64'd14);
      check("m3_1", 64'(m3[1]), 64'd4);
      check("m3_2", 64'(m3[2]), 64'd19);
      check("m3_3", 64'(m3[3]), 64'd20);

      xfer(4'd5, 4'd6, 4'd7, 4'd0, 0, 1'b0);       // zero length
      fill_mem();
      xfer(4'd14, 4'd15, 4'd15, 4'd3, 0, 1'b0);    // address wrap
      xfer(4'd0, 4'd0, 4'd0, 4'd4, 7, 1'b0);       // abort in second word's ADD
      xfer(4'd1, 4'd2, 4'd3, 4'd5, 0, 1'b1);       // second start ignored
      xfer(4'd2, 4'd9, 4'd4, 4'd3, 12, 1'b0);      // abort during WR keeps that write

`ifdef MEM_ADD_OVF_CNT_EN
      m1[0] = 8'd200; m1[1] = 8'd100;
      m2[0] = 8'd100; m2[1] = 8'd100;
      xfer(4'd0, 4'd0, 4'd0, 4'd2, 0, 1'b0);
      check("ovf_m3_0", 64'(m3[0]), 64'd44);
      check("ovf_m3_1", 64'(m3[1]), 64'd200);
      check("ovf_value", 64'(ovf_cnt), 64'd1);
`endif

      // Reset asserted in the WR cycle of the second word, after an ignored mid-transfer start.
      fill_mem();
      @(posedge clk); #1;
      src1_addr = '0; src2_addr = '0; dst_addr = '0; len = 4'd4; start = 1'b1;
      b_w = wr_q.size();
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; start = 1'b1; src1_addr = 4'd9; len = 4'd1;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_outs", outs(), 64'd0);
      check("rst_mid_wr_count", 64'(wr_q.size() - b_w), 64'd1);
      if (wr_q.size() > b_w)
         check("rst_mid_wr0", 64'(wr_q[b_w]), 64'({4'd0, DW'(m1[0] + m2[0])}));
      @(posedge clk); #1 rst_n = 1'b1;
      b_b = busy_cnt;
      repeat (10) @(negedge clk);
      check("rst_no_late_wr", 64'(wr_q.size() - b_w), 64'd1);
      check("rst_stays_idle", 64'(busy_cnt - b_b), 64'd0);

      // Randomized transfers.
      for (int t = 0; t < 30; t++) begin
         fill_mem();
         rl = AW'($urandom_range(0, DEPTH - 1));
         ab = 0;
         if (rl != 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, 4 * int'(rl));
         xfer(AW'($urandom), AW'($urandom), AW'($urandom), rl, ab,
              (rl != 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
